// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types used by the memory arbiter and its neighbours.
//   - word_t      : 32-bit machine word
//   - ramstate_t  : status reported by the RAM model each cycle
//   - arbstate_t  : mem_arbiter FSM state (also exported on its debug port)
//   - ARB_CNT_W   : width of the arbiter grant timer
package cpu_types_pkg;

   localparam int WORD_W    = 32;
   localparam int ARB_CNT_W = 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises instruction-fetch and data requests onto the single-ported
//   system RAM, one transaction at a time, and returns per-requester waits.
//   Flags RAM errors and grants that stay open too long (sticky memerr).
//
// Ports
//   CLK, nRST               clock, asynchronous active-low reset
//   iREN, iaddr             instruction read request / address
//   iwait, iload            instruction not-done flag / read data
//   dREN, dWEN, daddr,      data read / write request, address,
//   dstore                  write value
//   dwait, dload            data not-done flag / read data
//   ramREN, ramWEN,         RAM strobes, address, write data
//   ramaddr, ramstore
//   ramload, ramstate       RAM read data / RAM status
//   memerr                  sticky error flag (cleared only by reset)
//   arbstate                debug: current FSM state
//
// Handshake: a requester holds its enable until its wait goes low. Wait low
// happens combinationally in the grant cycle where ramstate == ACCESS; read
// data (iload/dload) is only meaningful in that cycle. Every grant returns
// to IDLE before the next grant, so a requester still holding its enable in
// its completion cycle is never issued twice.
//
// Configuration
//   MEM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests seen in IDLE
//                           alternate using a last-grant register; otherwise
//                           data always wins.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  word_t       iaddr,
   output logic        iwait,
   output word_t       iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  word_t       daddr,
   input  word_t       dstore,
   output logic        dwait,
   output word_t       dload,
   output logic        ramREN,
   output logic        ramWEN,
   output word_t       ramaddr,
   output word_t       ramstore,
   input  word_t       ramload,
   input  ramstate_t   ramstate,
   output logic        memerr,
   output arbstate_t   arbstate
);

   localparam logic [ARB_CNT_W-1:0] LIMIT_C = ARB_CNT_W'(WAIT_LIMIT);

   arbstate_t              state, nxt_state;
   logic [ARB_CNT_W-1:0]   cnt, cnt_inc;
   logic                   dreq;
   logic                   pick_d;
   logic                   in_grant;

   assign dreq     = dREN | dWEN;
   assign in_grant = (state != IDLE);
   assign arbstate = state;

   // Read data is a straight passthrough; the waits say when it is valid.
   assign iload = ramload;
   assign dload = ramload;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // last_d: 1 = last grant went to data, 0 = instruction.
   logic last_d;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_d <= 1'b0;
      end else if (state == IDLE && nxt_state != IDLE) begin
         last_d <= (nxt_state == DGNT);
      end
   end

   // Data wins unless the instruction side is also waiting and data had
   // the previous grant.
   assign pick_d = dreq & (~iREN | ~last_d);
`else
   assign pick_d = dreq;
`endif

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // Next-state logic
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: begin
            if (pick_d) begin
               nxt_state = DGNT;
            end else if (iREN) begin
               nxt_state = IGNT;
            end
         end
         // Completion or a dropped request both close the grant.
         IGNT: begin
            if (!iREN || ramstate == ACCESS) begin
               nxt_state = IDLE;
            end
         end
         DGNT: begin
            if (!dreq || ramstate == ACCESS) begin
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Output mux. Strobes follow the live request inputs so that a requester
   // dropping its enable mid-grant stops driving the RAM in that cycle.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (state)
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (ramstate == ACCESS) begin
               iwait = 1'b0;
            end
         end
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            // A write takes precedence over a read raised at the same time.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ramstate == ACCESS) begin
               dwait = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Grant timer, saturating. Held at zero in IDLE so every grant starts
   // counting from zero; after the Nth grant cycle it holds N.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt    <= '0;
         memerr <= 1'b0;
      end else begin
         if (in_grant) begin
            cnt <= cnt_inc;
         end else begin
            cnt <= '0;
         end
         // ERROR keeps the grant open for a retry but is remembered here;
         // likewise a grant reaching WAIT_LIMIT cycles without ACCESS.
         if (in_grant &&
             (ramstate == ERROR ||
              (ramstate != ACCESS && cnt_inc >= LIMIT_C))) begin
            memerr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: instruction read, simultaneous requests,
//   data write, RAM error, stuck RAM, request abort and reset mid-grant.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   // ---------------- clock / reset ----------------
   logic      CLK = 1'b0;
   logic      nRST;
   always #5 CLK = ~CLK;

   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN, memerr;
   word_t     iload, dload, ramaddr, ramstore;
   arbstate_t arbstate;

   mem_arbiter #(.WAIT_LIMIT(16)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .memerr   (memerr),
      .arbstate (arbstate)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Step to 1 ns after the next rising edge; inputs are driven there and
   // outputs are sampled 1 ns later, well clear of the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      iaddr    = '0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      idle_inputs();
      @(negedge CLK);
      nRST = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      nRST = 1'b0;
      idle_inputs();
      #1;
      check("rst_state",    32'(arbstate), 32'(IDLE));
      check("rst_ramREN",   32'(ramREN),   32'd0);
      check("rst_ramWEN",   32'(ramWEN),   32'd0);
      check("rst_ramaddr",  ramaddr,       32'h0);
      check("rst_ramstore", ramstore,      32'h0);
      check("rst_iwait",    32'(iwait),    32'd1);
      check("rst_dwait",    32'(dwait),    32'd1);
      check("rst_memerr",   32'(memerr),   32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      tick();

      // ---- 1: instruction read ----
      iREN = 1'b1; iaddr = 32'h100;
      #1;
      check("t1_c1_state",  32'(arbstate), 32'(IDLE));
      check("t1_c1_ramREN", 32'(ramREN),   32'd0);
      tick();
      ramstate = ACCESS; ramload = 32'h8C220004;
      #1;
      check("t1_c2_state",    32'(arbstate), 32'(IGNT));
      check("t1_c2_ramREN",   32'(ramREN),   32'd1);
      check("t1_c2_ramWEN",   32'(ramWEN),   32'd0);
      check("t1_c2_ramaddr",  ramaddr,       32'h100);
      check("t1_c2_ramstore", ramstore,      32'h0);
      check("t1_c2_iwait",    32'(iwait),    32'd0);
      check("t1_c2_dwait",    32'(dwait),    32'd1);
      check("t1_c2_iload",    iload,         32'h8C220004);
      tick();
      iREN = 1'b0; ramstate = FREE;
      #1;
      check("t1_c3_state", 32'(arbstate), 32'(IDLE));

      // ---- 2: simultaneous requests ----
      tick();
      iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h2000;
      #1;
      check("t2_idle", 32'(arbstate), 32'(IDLE));
      tick();
      ramstate = ACCESS; ramload = 32'h11112222;
      #1;
      check("t2_g1_state",   32'(arbstate), 32'(DGNT));
      check("t2_g1_ramaddr", ramaddr,       32'h2000);
      check("t2_g1_ramREN",  32'(ramREN),   32'd1);
      check("t2_g1_dwait",   32'(dwait),    32'd0);
      check("t2_g1_iwait",   32'(iwait),    32'd1);
      check("t2_g1_dload",   dload,         32'h11112222);
      tick();
      ramstate = FREE;   // both requesters keep asking
      #1;
      check("t2_bubble_state",  32'(arbstate), 32'(IDLE));
      check("t2_bubble_ramREN", 32'(ramREN),   32'd0);
      tick();
      ramstate = ACCESS;
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("t2_g2_state",   32'(arbstate), 32'(IGNT));
      check("t2_g2_ramaddr", ramaddr,       32'h104);
`else
      check("t2_g2_state",   32'(arbstate), 32'(DGNT));
      check("t2_g2_ramaddr", ramaddr,       32'h2000);
`endif
      tick();
      dREN = 1'b0; ramstate = FREE;
      #1;
      check("t2_bubble2", 32'(arbstate), 32'(IDLE));
      tick();
      ramstate = ACCESS;
      #1;
      check("t2_g3_state", 32'(arbstate), 32'(IGNT));
      check("t2_g3_iwait", 32'(iwait),    32'd0);
      tick();
      iREN = 1'b0; ramstate = FREE;

      // ---- 3: data write (write wins over read) ----
      dWEN = 1'b1; dREN = 1'b1; dstore = 32'hDEADBEEF; daddr = 32'h40;
      #1;
      check("t3_idle", 32'(arbstate), 32'(IDLE));
      tick();
      ramstate = BUSY;
      #1;
      check("t3_ramWEN",   32'(ramWEN), 32'd1);
      check("t3_ramREN",   32'(ramREN), 32'd0);
      check("t3_ramstore", ramstore,    32'hDEADBEEF);
      check("t3_ramaddr",  ramaddr,     32'h40);
      check("t3_busy_dwait", 32'(dwait), 32'd1);
      tick();
      ramstate = ACCESS;
      #1;
      check("t3_acc_dwait", 32'(dwait), 32'd0);
      tick();
      dWEN = 1'b0; dREN = 1'b0; ramstate = FREE;
      #1;
      check("t3_end_state", 32'(arbstate), 32'(IDLE));

      // ---- request dropped mid-grant ----
      tick();
      iREN = 1'b1; iaddr = 32'h200;
      tick();
      ramstate = BUSY;
      iREN = 1'b0;
      #1;
      check("ab_state",  32'(arbstate), 32'(IGNT));
      check("ab_ramREN", 32'(ramREN),   32'd0);
      tick();
      ramstate = FREE;
      #1;
      check("ab_idle", 32'(arbstate), 32'(IDLE));

      // ---- 4: RAM error then success ----
      tick();
      dREN = 1'b1; daddr = 32'h80;
      tick();
      ramstate = BUSY;
      #1;
      check("t4_busy_memerr", 32'(memerr), 32'd0);
      tick();
      ramstate = ERROR;
      #1;
      check("t4_err_memerr", 32'(memerr), 32'd0);
      check("t4_err_dwait",  32'(dwait),  32'd1);
      tick();
      ramstate = ACCESS;
      #1;
      check("t4_acc_memerr", 32'(memerr),   32'd1);
      check("t4_acc_state",  32'(arbstate), 32'(DGNT));
      check("t4_acc_dwait",  32'(dwait),    32'd0);
      tick();
      dREN = 1'b0; ramstate = FREE;
      #1;
      check("t4_end_state",  32'(arbstate), 32'(IDLE));
      check("t4_end_memerr", 32'(memerr),   32'd1);
      do_reset();
      #1;
      check("t4_rst_memerr", 32'(memerr), 32'd0);

      // ---- 5: stuck RAM, WAIT_LIMIT = 16 ----
      iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
      tick();
      for (int k = 1; k <= 20; k++) begin
         #1;
         check($sformatf("t5_memerr_c%0d", k), 32'(memerr), (k >= 17) ? 32'd1 : 32'd0);
         check($sformatf("t5_iwait_c%0d", k),  32'(iwait),  32'd1);
         tick();
      end
      ramstate = ACCESS;
      #1;
      check("t5_acc_state", 32'(arbstate), 32'(IGNT));
      check("t5_acc_iwait", 32'(iwait),    32'd0);
      tick();
      iREN = 1'b0; ramstate = FREE;

      // ---- 6: reset mid-grant ----
      do_reset();
      dREN = 1'b1; daddr = 32'h600;
      tick();
      ramstate = BUSY;
      #1;
      check("t6_pre_state",  32'(arbstate), 32'(DGNT));
      check("t6_pre_ramREN", 32'(ramREN),   32'd1);
      #1;
      nRST = 1'b0;
      #1;
      check("t6_rst_state",   32'(arbstate), 32'(IDLE));
      check("t6_rst_ramREN",  32'(ramREN),   32'd0);
      check("t6_rst_ramaddr", ramaddr,       32'h0);
      check("t6_rst_dwait",   32'(dwait),    32'd1);
      check("t6_rst_iwait",   32'(iwait),    32'd1);
      dREN = 1'b0; iREN = 1'b1; iaddr = 32'h500; ramstate = FREE;
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      #1;
      check("t6_post_state",   32'(arbstate), 32'(IGNT));
      check("t6_post_ramaddr", ramaddr,       32'h500);
      check("t6_post_ramREN",  32'(ramREN),   32'd1);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter between the instruction-fetch and data request paths and the single-ported system RAM. It sits between the request unit / datapath cache interface and the RAM model. It serialises `iREN` and `dREN`/`dWEN` requests into one RAM transaction at a time and returns per-requester wait signals. It also flags RAM errors and stuck transactions.

## Interface
Parameters:
- `WAIT_LIMIT`, 16: number of cycles a grant may stay open without `ramstate == ACCESS` before `memerr` is set.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction address.
- `iwait`  out  1  instruction request not yet complete.
- `iload`  out  32  instruction read data.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `dwait`  out  1  data request not yet complete.
- `dload`  out  32  data read data.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  32  RAM address and write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `memerr`  out  1  sticky error flag.

## Operation
- The FSM has three states: IDLE, IGNT, DGNT.
- **IDLE:**
  - If a data request is pending (`dREN | dWEN`) → DGNT.
  - Else if `iREN` → IGNT.
  - Else stay in IDLE.
  - RAM strobes are 0 in this state.
- **DGNT:**
  - `ramaddr = daddr`, `ramstore = dstore`.
  - If `dWEN` is high: `ramWEN = 1`, `ramREN = 0`. A write wins when both `dWEN` and `dREN` are asserted.
  - Else: `ramREN = 1`, `ramWEN = 0`.
- **IGNT:**
  - `ramaddr = iaddr`, `ramREN = 1`, `ramWEN = 0`, `ramstore = 0`.
- **Completion:**
  - In a grant state with `ramstate == ACCESS`, the granted requester's wait goes low combinationally in that same cycle.
  - The FSM then returns to IDLE on the next edge.
  - There is no direct grant-to-grant transition. The requester still holds its enable in the completing cycle, so a direct transition would double-issue. The cost is a one-cycle IDLE bubble, which is mandatory.
- **Wait signals:** `iwait` and `dwait` are 1 at all times except in their own completion cycle.
- **Read data:** `iload = dload = ramload`, as combinational passthroughs. They are valid only when the matching wait is low.
- **Request dropped mid-grant:** if the granted requester drops its enable mid-grant, the FSM aborts to IDLE on the next edge. Strobes follow the inputs, so they are 0 in that cycle.
- **RAM error:** `ramstate == ERROR` in a grant sets `memerr`. The grant stays open and the transaction is retried.
- **Grant timer:** an 8-bit cycle counter clears on every grant entry and increments each grant cycle. When it reaches `WAIT_LIMIT` without ACCESS, `memerr` is set. The counter saturates.

## Timing
- Reset values: state IDLE, `ramREN = ramWEN = 0`, `ramaddr = ramstore = 0`, `iwait = dwait = 1`, `memerr = 0`, counter 0, last-grant = instruction.
- Request latency: a request first seen in IDLE drives the RAM strobes in the following cycle.
- Minimum transaction: 2 cycles, one IDLE cycle plus one grant cycle with ACCESS.
- `memerr` clears only on reset.
- Reset asserted mid-grant forces the reset values immediately, independent of the clock.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - When both requesters are pending in IDLE, grant the one opposite to the last-grant register.
  - The last-grant register updates on every grant entry.
- Not defined:
  - Fixed priority, data always wins.
  - The last-grant register is not instantiated.

## Structure
- `cpu_types_pkg` holds:
  - `ramstate_t`
  - `word_t`
  - a new `arbstate_t` enum {IDLE, IGNT, DGNT}
  - `ARB_CNT_W = 8`
- No sub-module. The FSM, counter and output mux live in one module.

## Test plan
1. **Instruction read:** `iREN = 1`, `iaddr = 0x100`, `ramstate` = ACCESS on the 2nd cycle with `ramload = 0x8C220004` → `ramREN = 1` and `ramaddr = 0x100` in cycle 2; `iwait = 0` in cycle 2; IDLE in cycle 3.
2. **Simultaneous requests:** `iREN` and `dREN` both asserted, `daddr = 0x2000` → data is served first, then instruction. With `MEM_ARB_ROUND_ROBIN_EN` and last-grant = data, the instruction is served first.
3. **Data write:** `dWEN = 1`, `dREN = 1`, `dstore = 0xDEADBEEF`, `daddr = 0x40` → `ramWEN = 1`, `ramREN = 0`, `ramstore = 0xDEADBEEF`; `dwait` low on ACCESS.
4. **RAM error then success:** `ramstate` = BUSY, ERROR, then ACCESS → `memerr` becomes 1 after ERROR and stays 1; the transaction completes on ACCESS.
5. **Stuck RAM:** `ramstate` held BUSY for 20 cycles with `WAIT_LIMIT = 16` → `memerr` rises after the 16th grant cycle; waits stay 1.
6. **Reset mid-grant:** `nRST` pulled low in DGNT → outputs take their reset values immediately; after release, with `iREN = 1`, the FSM enters IGNT normally.
